// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared encodings for the operand loader
package operand_loader_pkg;

  localparam int BITS_DEF = 32;
  localparam int SWW_DEF  = 8;

  typedef enum logic [1:0] {
    ENTER = 2'd0,
    LOAD  = 2'd1,
    FIRE  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int BTN_ENTER  = 0;
  localparam int BTN_NEXT   = 1;
  localparam int BTN_START  = 2;
  localparam int BTN_CLEAR  = 3;
  localparam int BTN_UNUSED = 4;

  localparam logic [1:0] SEL_M = 2'd0;
  localparam logic [1:0] SEL_E = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;

  // Operand select steps M -> E -> N -> M.
  function automatic logic [1:0] next_sel(input logic [1:0] s);
    return (s == SEL_N) ? SEL_M : s + 2'd1;
  endfunction

endpackage

// File: rtl/operand_loader_btn_edge.sv
// rtl/operand_loader_btn_edge.sv - button history register and rising-edge pulses
module operand_loader_btn_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btns,
  output logic [W-1:0] rise
);

  logic [W-1:0] btns_q;

  // Remember last cycle's button levels so a held press fires only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btns_q <= '0;
    else       btns_q <= btns;
  end

  assign rise = btns & ~btns_q;

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - switch/button front-end that builds M/E/N and launches the engine
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int SWW  = SWW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SWW-1:0]  db_sw,
  input  logic [4:0]      db_btns,
  input  logic            done,
  output logic [BITS-1:0] M,
  output logic [BITS-1:0] E,
  output logic [BITS-1:0] N,
  output logic            load,
  output logic            go,
  output logic [1:0]      sel,
  output logic [1:0]      byte_idx,
  output logic            busy,
  output logic            err
);

  localparam int NBYTES = BITS / SWW;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  logic [4:0]      rise;
  logic            unused_btn;
  state_t          state, state_n;
  logic [BITS-1:0] m_n, e_n, n_n;
  logic [1:0]      sel_n, idx_n;
  logic            busy_n, err_n;

  operand_loader_btn_edge #(.W(5)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btns  (db_btns),
    .rise  (rise)
  );

  assign unused_btn = rise[BTN_UNUSED];

  // State and operand registers; everything returns to idle on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ENTER;
      M        <= '0;
      E        <= '0;
      N        <= '0;
      sel      <= SEL_M;
      byte_idx <= 2'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      M        <= m_n;
      E        <= e_n;
      N        <= n_n;
      sel      <= sel_n;
      byte_idx <= idx_n;
      busy     <= busy_n;
      err      <= err_n;
    end
  end

  // Next-state and strobes; clear wins, then start, next, enter.
  always_comb begin
    state_n = state;
    m_n     = M;
    e_n     = E;
    n_n     = N;
    sel_n   = sel;
    idx_n   = byte_idx;
    busy_n  = busy;
    err_n   = err;
    load    = 1'b0;
    go      = 1'b0;

    if (rise[BTN_CLEAR]) begin
      state_n = ENTER;
      m_n     = '0;
      e_n     = '0;
      n_n     = '0;
      sel_n   = SEL_M;
      idx_n   = 2'd0;
      busy_n  = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        ENTER: begin
          if (rise[BTN_START]) begin
            // An even modulus (zero included) cannot be used by Montgomery reduction.
            if (N[0]) begin
              err_n   = 1'b0;
              state_n = LOAD;
            end else begin
              err_n = 1'b1;
            end
          end else if (rise[BTN_NEXT]) begin
            sel_n = next_sel(sel);
            idx_n = 2'd0;
          end else if (rise[BTN_ENTER]) begin
            case (sel)
              SEL_M:   m_n = {M[BITS-SWW-1:0], db_sw};
              SEL_E:   e_n = {E[BITS-SWW-1:0], db_sw};
              default: n_n = {N[BITS-SWW-1:0], db_sw};
            endcase
            if (byte_idx == LAST_IDX) begin
              idx_n = 2'd0;
              sel_n = next_sel(sel);
            end else begin
              idx_n = byte_idx + 2'd1;
            end
          end
        end
        LOAD: begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = FIRE;
        end
        FIRE: begin
          go      = 1'b1;
          state_n = WAIT;
        end
        WAIT: begin
          if (done) begin
            busy_n  = 1'b0;
            state_n = ENTER;
          end
        end
        default: state_n = ENTER;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  db_sw = 8'h00;
  logic [4:0]  db_btns = 5'b0;
  logic        done = 1'b0;
  logic [31:0] M, E, N;
  logic        load, go, busy, err;
  logic [1:0]  sel, byte_idx;

  int vectors = 0;
  int miscompares = 0;
  int n_load = 0;
  int n_go = 0;
  int ld0, go0;

  operand_loader dut (
    .clk      (clk),
    .reset    (reset),
    .db_sw    (db_sw),
    .db_btns  (db_btns),
    .done     (done),
    .M        (M),
    .E        (E),
    .N        (N),
    .load     (load),
    .go       (go),
    .sel      (sel),
    .byte_idx (byte_idx),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) n_load++;
    if (go)   n_go++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    db_btns = b;
    tick();
    db_btns = 5'b0;
  endtask

  task automatic enter_byte(input logic [7:0] b);
    db_sw = b;
    press(5'b00001);
    tick();
  endtask

  task automatic next_op;
    press(5'b00010);
    tick();
  endtask

  task automatic enter_word(input logic [31:0] w);
    enter_byte(w[31:24]);
    enter_byte(w[23:16]);
    enter_byte(w[15:8]);
    enter_byte(w[7:0]);
  endtask

  task automatic finish_run;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_M", M, 32'h0);
    check("rst_E", E, 32'h0);
    check("rst_N", N, 32'h0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_idx", 32'(byte_idx), 32'd0);
    check("rst_strobes", {28'd0, load, go, busy, err}, 32'h0);
    reset = 1'b0;
    tick();

    enter_byte(8'h12);
    check("idx_after_1", 32'(byte_idx), 32'd1);
    enter_byte(8'h34);
    enter_byte(8'h56);
    enter_byte(8'h78);
    check("M_word", M, 32'h12345678);
    check("sel_after_M", 32'(sel), 32'd1);
    check("idx_wrap", 32'(byte_idx), 32'd0);
    check("E_still_0", E, 32'h0);
    check("N_still_0", N, 32'h0);

    enter_word(32'h00010001);
    enter_word(32'h0000D0A1);
    check("E_word", E, 32'h00010001);
    check("N_word", N, 32'h0000D0A1);
    check("sel_wrap", 32'(sel), 32'd0);

    // Start latency: load one cycle after the start edge, go the cycle after that.
    ld0 = n_load; go0 = n_go;
    press(5'b00100);
    check("t1_load", 32'(load), 32'd1);
    check("t1_go", 32'(go), 32'd0);
    tick();
    check("t2_go", 32'(go), 32'd1);
    check("t2_load", 32'(load), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    tick();
    ld0 = n_load; go0 = n_go;
    for (int i = 0; i < 25; i++) begin
      db_sw = 8'hFF;
      press(5'b00100);
      tick();
      press(5'b00001);
      tick();
    end
    check("wait_M", M, 32'h12345678);
    check("wait_E", E, 32'h00010001);
    check("wait_N", N, 32'h0000D0A1);
    check("wait_loads", n_load - ld0, 32'd0);
    check("wait_gos", n_go - go0, 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    check("done_busy", 32'(busy), 32'd0);
    done = 1'b0;
    tick();
    enter_byte(8'hAA);
    check("after_done_M", M, 32'h345678AA);
    check("after_done_idx", 32'(byte_idx), 32'd1);

    // Even modulus refused.
    next_op();
    next_op();
    check("next_sel", 32'(sel), 32'd2);
    check("next_idx", 32'(byte_idx), 32'd0);
    enter_word(32'h0000D0A0);
    check("N_even", N, 32'h0000D0A0);
    ld0 = n_load; go0 = n_go;
    press(5'b00100);
    tick();
    tick();
    check("even_err", 32'(err), 32'd1);
    check("even_loads", n_load - ld0, 32'd0);
    check("even_gos", n_go - go0, 32'd0);
    next_op();
    next_op();
    enter_word(32'h0000D0A1);
    press(5'b00100);
    check("odd_err_clr", 32'(err), 32'd0);
    check("odd_load", 32'(load), 32'd1);
    tick();
    tick();
    finish_run();

    // Coincident start/next/enter: only start acts.
    db_sw = 8'h55;
    ld0 = n_load;
    press(5'b00111);
    check("coin_load", 32'(load), 32'd1);
    check("coin_sel", 32'(sel), 32'd0);
    check("coin_idx", 32'(byte_idx), 32'd0);
    check("coin_M", M, 32'h345678AA);
    tick();
    tick();
    finish_run();
    check("coin_loads", n_load - ld0, 32'd1);

    // A long hold shifts exactly one byte.
    db_sw = 8'h99;
    db_btns = 5'b00001;
    repeat (50) tick();
    db_btns = 5'b0;
    tick();
    check("hold_M", M, 32'h5678AA99);
    check("hold_idx", 32'(byte_idx), 32'd1);

    // Clear during WAIT abandons the run.
    press(5'b00100);
    tick();
    tick();
    press(5'b01000);
    check("clr_load", 32'(load), 32'd0);
    check("clr_M", M, 32'h0);
    check("clr_E", E, 32'h0);
    check("clr_N", N, 32'h0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_sel_idx", {30'd0, sel} + {30'd0, byte_idx}, 32'd0);
    ld0 = n_load; go0 = n_go;
    done = 1'b1;
    repeat (5) tick();
    done = 1'b0;
    tick();
    check("clr_no_load", n_load - ld0, 32'd0);
    check("clr_no_go", n_go - go0, 32'd0);
    check("clr_busy_late", 32'(busy), 32'd0);

    // Asynchronous reset while load is high.
    next_op();
    next_op();
    enter_word(32'h00000001);
    press(5'b00100);
    check("pre_rst_load", 32'(load), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_load", 32'(load), 32'd0);
    check("async_N", N, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_go", 32'(go), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
